// File: rtl/fila_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fila_pkg
// Shared defaults and the enqueue FSM state type for the fila_bytes queue.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package fila_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 8;

  // ACCEPT waits for a new byte; WAIT_DROP waits for the request to fall
  typedef enum logic {
    ACCEPT    = 1'b0,
    WAIT_DROP = 1'b1
  } enq_state_t;

endpackage
`default_nettype wire

// File: rtl/fila_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fila_mem
// DEPTH x WIDTH register file: synchronous write port, registered read port.
// The array itself is never reset; only the read register clears.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module fila_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: storage only, contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: holds the last popped byte until the next pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fila_bytes.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fila_bytes
// Byte queue behind the serial-to-parallel deserializer. Captures one byte
// per data_ready level via a one-cycle ack, stores up to DEPTH bytes in
// arrival order and pops one byte per dequeue request.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module fila_bytes
  import fila_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       enqueue_in,
  output logic                       ack_out,
  input  logic                       dequeue_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic [$clog2(DEPTH):0]     len_out,
  output logic                       full_out,
  output logic                       empty_out
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  enq_state_t        state_q, state_d;
  logic              ack_q;
  logic              valid_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  // Flags come from the count registered at cycle start, so a same-cycle pop
  // never frees space for a write and a fresh write is never popped at once.
  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign w_empty = (count_q == '0);
  assign w_wr    = (state_q == ACCEPT) && enqueue_in && !w_full;
  assign w_rd    = dequeue_in && !w_empty;

  // Next-state for the enqueue FSM, pointers and occupancy
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      ACCEPT:    if (w_wr)        state_d = WAIT_DROP;
      WAIT_DROP: if (!enqueue_in) state_d = ACCEPT;
      default:                    state_d = ACCEPT;
    endcase

    if (w_wr) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (w_rd) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    if (w_wr && !w_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_wr && w_rd) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Enqueue FSM with registered one-cycle acknowledge
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      state_q <= ACCEPT;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= w_wr;
    end
  end

  // Pointers, occupancy and the pop-valid pulse
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= w_rd;
    end
  end

  fila_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk_i  (clk_100KHz),
    .rst_i  (reset),
    .we_i   (w_wr),
    .waddr_i(wr_ptr_q),
    .wdata_i(data_in),
    .re_i   (w_rd),
    .raddr_i(rd_ptr_q),
    .rdata_o(data_out)
  );

  assign ack_out        = ack_q;
  assign data_valid_out = valid_q;
  assign len_out        = count_q;
  assign full_out       = w_full;
  assign empty_out      = w_empty;

endmodule
`default_nettype wire
